// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: FSM encoding and sentinel constants shared by seq_match_scheduler
package seq_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SHIFT  = 3'b010,
    ST_REPORT = 3'b100
  } state_t;
  localparam logic [31:0] POS_NONE = '1;
endpackage

// File: rtl/serial_pattern_matcher.sv
// serial_pattern_matcher: MSB-first serial detector counting overlapping pattern hits and the first hit position
module serial_pattern_matcher
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int DATA_W = 16,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] first_pos
);
  logic [PAT_W-1:0] win, nwin;
  logic [CNT_W-1:0] fill;
  assign nwin = PAT_W'({win, bit_in});
  // fill equals the index of the bit being received, so it doubles as the hit position
  assign match = bit_en && fill >= CNT_W'(PAT_W - 1) && nwin == pattern;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      win <= '0;
      fill <= '0;
      count <= '0;
      first_pos <= POS_NONE[CNT_W-1:0];
    end else if (bit_en) begin
      win <= nwin;
      fill <= fill + 1'b1;
      if (match) begin
        count <= count + 1'b1;
        if (count == '0) first_pos <= fill;
      end
    end
  end
endmodule

// File: rtl/seq_match_scheduler.sv
// seq_match_scheduler: round-robin sharing of one serial pattern matcher among N_REQ requesters
module seq_match_scheduler
  import seq_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 16,
  parameter int PAT_W = 4,
  localparam int CNT_W = $clog2(DATA_W + 1),
  localparam int POS_W = CNT_W,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [PAT_W-1:0]        cfg_pattern,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CNT_W-1:0]        rsp_count,
  output logic [POS_W-1:0]        rsp_first_pos,
  output logic                    busy
);
  state_t state, state_d;
  logic [ID_W-1:0] rr_ptr, gnt_idx, cand;
  logic gnt_any, accept, last;
  logic [DATA_W-1:0] cap;
  logic [PAT_W-1:0] pat;
  logic [POS_W-1:0] bit_idx;
  // scan from farthest to nearest so the requester closest to rr_ptr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  assign accept = state == ST_IDLE && !rst && gnt_any;
  assign req_ready = accept ? N_REQ'(1) << gnt_idx : '0;
  assign last = bit_idx == POS_W'(DATA_W - 1);
  assign rsp_valid = state == ST_REPORT;
  assign busy = state != ST_IDLE;
  always_comb begin
    state_d = state == ST_IDLE   ? (gnt_any ? ST_SHIFT : ST_IDLE) :
              state == ST_SHIFT  ? (last ? ST_REPORT : ST_SHIFT) :
              state == ST_REPORT ? (rsp_ready ? ST_IDLE : ST_REPORT) : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rr_ptr <= '0;
      rsp_id <= '0;
      cap <= '0;
      pat <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        rr_ptr <= ID_W'((int'(gnt_idx) + 1) % N_REQ);
        rsp_id <= gnt_idx;
        cap <= req_data[gnt_idx*DATA_W +: DATA_W];
        pat <= cfg_pattern;
        bit_idx <= '0;
      end else if (state == ST_SHIFT) begin
        cap <= cap << 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
  serial_pattern_matcher #(.PAT_W(PAT_W), .DATA_W(DATA_W)) u_matcher (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .bit_en(state == ST_SHIFT),
    .bit_in(cap[DATA_W-1]),
    .pattern(pat),
    .match(),
    .count(rsp_count),
    .first_pos(rsp_first_pos)
  );
endmodule

// File: tb/tb_seq_match_scheduler.sv
// tb_seq_match_scheduler: randomized checks of seq_match_scheduler against a behavioural model
module tb_seq_match_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0] cfg_pattern = '0;
  logic rsp_ready = 1'b0;
  logic [3:0] req_ready;
  logic rsp_valid, busy;
  logic [1:0] rsp_id;
  logic [4:0] rsp_count, rsp_first_pos;
  int checks = 0;
  int errors = 0;
  int rrm = 0;

  always #5 clk = ~clk;

  seq_match_scheduler #(.N_REQ(4), .DATA_W(16), .PAT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_pattern(cfg_pattern), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_first_pos(rsp_first_pos), .busy(busy)
  );

  function automatic int model_grant(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[(rrm + i) % 4]) return (rrm + i) % 4;
    return 0;
  endfunction

  // the window seen at bit k holds word bits [18-k : 15-k]
  task automatic model_match(input logic [15:0] w, input logic [3:0] p, output int c, output int f);
    c = 0;
    f = 31;
    for (int k = 3; k < 16; k++)
      if (((w >> (15 - k)) & 16'hF) == {12'h0, p}) begin
        if (c == 0) f = k;
        c++;
      end
  endtask

  task automatic run_job(input logic [3:0] vm, input logic [63:0] d, input logic [3:0] p,
                         input int stall, input string tag);
    int g, cyc, ec, ef;
    @(negedge clk);
    req_valid = vm;
    req_data = d;
    cfg_pattern = p;
    rsp_ready = 1'b0;
    #1;
    g = model_grant(vm);
    model_match(d[g*16 +: 16], p, ec, ef);
    checks++;
    if (req_ready !== 4'(1 << g)) begin
      errors++;
      $display("FAIL %s grant: req_ready=%b want %b", tag, req_ready, 4'(1 << g));
    end
    @(negedge clk);
    rrm = (g + 1) % 4;
    req_valid = '0;
    req_data = {$urandom, $urandom};
    cfg_pattern = 4'($urandom);
    checks++;
    if (req_ready !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s after accept: req_ready=%b busy=%b want 0000/1", tag, req_ready, busy);
    end
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 16) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want 16", tag, cyc);
    end
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        req_valid = 4'hF;
        @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL %s report hold %0d: valid=%b busy=%b req_ready=%b want 1/1/0000",
                 tag, s, rsp_valid, busy, req_ready);
      end
      checks++;
      if (rsp_id !== 2'(g) || rsp_count !== 5'(ec) || rsp_first_pos !== 5'(ef)) begin
        errors++;
        $display("FAIL %s result %0d: id=%0d count=%0d pos=%0d want id=%0d count=%0d pos=%0d",
                 tag, s, rsp_id, rsp_count, rsp_first_pos, g, ec, ef);
      end
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: valid=%b busy=%b want 0/0", tag, rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: req_ready=%b valid=%b busy=%b want 0000/0/0", req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_count !== 5'd0 || rsp_first_pos !== 5'h1F) begin
      errors++;
      $display("FAIL reset data: id=%0d count=%0d pos=%0h want 0/0/1f", rsp_id, rsp_count, rsp_first_pos);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    rrm = 0;
  endtask

  task automatic test_single();
    run_job(4'b0001, {48'h0, 16'hB000}, 4'b1011, 0, "single_b000");
    run_job(4'b0001, {48'h0, 16'hFFFF}, 4'b1111, 0, "overlap_ffff");
    run_job(4'b0001, {48'h0, 16'h0000}, 4'b1011, 0, "nohit_0000");
  endtask

  task automatic test_rr_order(input bit drop);
    int n, t, g, target;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rrm = 0;
    req_data = {$urandom, $urandom};
    cfg_pattern = 4'($urandom);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    target = drop ? 4 : 5;
    n = 0;
    t = 0;
    while (n < target && t < 400) begin
      #1;
      if (req_ready !== 4'b0) begin
        g = model_grant(req_valid);
        checks++;
        if (req_ready !== 4'(1 << g)) begin
          errors++;
          $display("FAIL rr_order drop=%0d grant %0d: req_ready=%b want %b", drop, n, req_ready, 4'(1 << g));
        end
        rrm = (g + 1) % 4;
        n++;
        if (drop && n == 1) req_valid[1] = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    checks++;
    if (n != target) begin
      errors++;
      $display("FAIL rr_order drop=%0d timeout: got %0d grants want %0d", drop, n, target);
    end
    req_valid = '0;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_order drain: busy=%b want 0", busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    run_job(4'b0010, {$urandom, $urandom}, 4'($urandom), 5, "stall");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0100;
    req_data = {$urandom, $urandom};
    cfg_pattern = 4'($urandom);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid pre: busy=%b valid=%b want 1/0", busy, rsp_valid);
    end
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid ctrl: busy=%b valid=%b req_ready=%b want 0/0/0000", busy, rsp_valid, req_ready);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_count !== 5'd0 || rsp_first_pos !== 5'h1F) begin
      errors++;
      $display("FAIL reset_mid data: id=%0d count=%0d pos=%0h want 0/0/1f", rsp_id, rsp_count, rsp_first_pos);
    end
    repeat (2) @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    rrm = 0;
    run_job(4'hF, {$urandom, $urandom}, 4'($urandom), 0, "after_reset");
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++)
      run_job(4'($urandom_range(1, 15)), {$urandom, $urandom}, 4'($urandom), $urandom_range(0, 3), "random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order(1'b0);
    test_rr_order(1'b1);
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
